// File: rtl/mig_multiport_if_if.sv
// Requester-side and MIG-side signal bundle for the multiport MIG front end.
// The controller uses the slave modport; the environment (requesters plus MIG) uses master.
// Vector signals carry one slice per port, with port p at slice p.
interface mig_multiport_if_if #(
  parameter int NUM_PORTS        = 2,
  parameter int APPDATA_WIDTH    = 128,
  parameter int BEATS            = 2,
  parameter int INPUT_ADDR_WIDTH = 31
);
  logic                                      phy_init_done;
  logic [NUM_PORTS-1:0]                      req_wren;
  logic [NUM_PORTS-1:0]                      req_rden;
  logic [NUM_PORTS*INPUT_ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_PORTS*BEATS*APPDATA_WIDTH-1:0]  req_wr_data;
  logic [NUM_PORTS-1:0]                      req_ack;
  logic [NUM_PORTS-1:0]                      rd_valid;
  logic [NUM_PORTS-1:0]                      rd_err;
  logic [BEATS*APPDATA_WIDTH-1:0]            rd_data;
  logic                                      app_af_afull;
  logic                                      app_wdf_afull;
  logic                                      rd_data_valid;
  logic [APPDATA_WIDTH-1:0]                  rd_data_fifo_out;
  logic                                      app_af_wren;
  logic [INPUT_ADDR_WIDTH-1:0]               app_af_addr;
  logic [2:0]                                app_af_cmd;
  logic                                      app_wdf_wren;
  logic [APPDATA_WIDTH-1:0]                  app_wdf_data;
  logic [APPDATA_WIDTH/8-1:0]                app_wdf_mask_data;

  modport slave (
    input  phy_init_done, req_wren, req_rden, req_addr, req_wr_data,
           app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    output req_ack, rd_valid, rd_err, rd_data,
           app_af_wren, app_af_addr, app_af_cmd, app_wdf_wren, app_wdf_data, app_wdf_mask_data
  );

  modport master (
    output phy_init_done, req_wren, req_rden, req_addr, req_wr_data,
           app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    input  req_ack, rd_valid, rd_err, rd_data,
           app_af_wren, app_af_addr, app_af_cmd, app_wdf_wren, app_wdf_data, app_wdf_mask_data
  );
endinterface

// File: rtl/mig_multiport_if.sv
// Round-robin multiport front end for a MIG controller; one line-sized transaction in flight.
// Latency: grant on the request edge, command and req_ack one edge later, write beats follow one per cycle.
// Backpressure: commands stall on app_af_afull/app_wdf_afull; write beats stall on app_wdf_afull; reads time out.
module mig_multiport_if #(
  parameter int NUM_PORTS        = 2,
  parameter int APPDATA_WIDTH    = 128,
  parameter int BEATS            = 2,
  parameter int INPUT_ADDR_WIDTH = 31,
  parameter int RD_TIMEOUT       = 1023
) (
  input logic              clk,
  input logic              rst_n,
  mig_multiport_if_if.slave bus
);
  localparam int W      = APPDATA_WIDTH;
  localparam int LINE_W = BEATS * APPDATA_WIDTH;
  localparam int AW     = INPUT_ADDR_WIDTH;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW     = $clog2(RD_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT} state_t;

  state_t                state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         port;
  logic [AW-1:0]         addr_q;
  logic [LINE_W-1:0]     wr_line;
  logic [LINE_W-1:0]     rd_line;
  logic [LINE_W-1:0]     line_nxt;
  logic [BW-1:0]         beat_cnt;
  logic [TW-1:0]         to_cnt;
  logic [NUM_PORTS-1:0]  pend;
  logic [NUM_PORTS-1:0]  port_oh;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_port;
  logic [PW-1:0]         rr_nxt;

  function automatic logic [PW-1:0] wrap_idx(input int i);
    return PW'(i % NUM_PORTS);
  endfunction

  // Mask is never used: every write covers the full beat.
  assign bus.app_wdf_mask_data = '0;
  assign port_oh = NUM_PORTS'(1) << port;
  assign rr_nxt  = (gnt_port == PW'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;

  // Round-robin pick: scan from rr_ptr upward; iterating backwards leaves the nearest requester selected.
  always_comb begin
    pend     = bus.req_wren | bus.req_rden;
    gnt_vld  = 1'b0;
    gnt_port = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (pend[wrap_idx(int'(rr_ptr) + k)]) begin
        gnt_vld  = 1'b1;
        gnt_port = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  // Read line with the incoming beat merged into its slot, so the final beat can land in rd_data on the same edge.
  always_comb begin
    line_nxt = rd_line;
    line_nxt[beat_cnt*W +: W] = bus.rd_data_fifo_out;
  end

  // Main controller FSM; all MIG strobes and requester pulses are registered here and default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      port             <= '0;
      addr_q           <= '0;
      wr_line          <= '0;
      rd_line          <= '0;
      beat_cnt         <= '0;
      to_cnt           <= '0;
      bus.req_ack      <= '0;
      bus.rd_valid     <= '0;
      bus.rd_err       <= '0;
      bus.rd_data      <= '0;
      bus.app_af_wren  <= 1'b0;
      bus.app_af_addr  <= '0;
      bus.app_af_cmd   <= '0;
      bus.app_wdf_wren <= 1'b0;
      bus.app_wdf_data <= '0;
    end else begin
      bus.req_ack      <= '0;
      bus.rd_valid     <= '0;
      bus.rd_err       <= '0;
      bus.app_af_wren  <= 1'b0;
      bus.app_wdf_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.phy_init_done && gnt_vld) begin
            port    <= gnt_port;
            rr_ptr  <= rr_nxt;
            addr_q  <= bus.req_addr[gnt_port*AW +: AW];
            wr_line <= bus.req_wr_data[gnt_port*LINE_W +: LINE_W];
            // A port asking for both gets its write first; the read stays pending.
            state   <= bus.req_wren[gnt_port] ? WR_CMD : RD_CMD;
          end
        end
        WR_CMD: begin
          if (!bus.app_af_afull && !bus.app_wdf_afull) begin
            bus.app_af_wren  <= 1'b1;
            bus.app_af_cmd   <= 3'b000;
            bus.app_af_addr  <= addr_q;
            bus.app_wdf_wren <= 1'b1;
            bus.app_wdf_data <= wr_line[W-1:0];
            bus.req_ack      <= port_oh;
            if (BEATS > 1) begin
              state    <= WR_DATA;
              beat_cnt <= BW'(1);
            end else begin
              state    <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (!bus.app_wdf_afull) begin
            bus.app_wdf_wren <= 1'b1;
            bus.app_wdf_data <= wr_line[beat_cnt*W +: W];
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RD_CMD: begin
          if (!bus.app_af_afull) begin
            bus.app_af_wren <= 1'b1;
            bus.app_af_cmd  <= 3'b001;
            bus.app_af_addr <= addr_q;
            bus.req_ack     <= port_oh;
            beat_cnt        <= '0;
            to_cnt          <= '0;
            state           <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.rd_data_valid && beat_cnt == LAST_BEAT) begin
            // Completion wins over a timeout expiring in the same cycle.
            rd_line      <= line_nxt;
            bus.rd_data  <= line_nxt;
            bus.rd_valid <= port_oh;
            beat_cnt     <= '0;
            to_cnt       <= '0;
            state        <= IDLE;
          end else begin
            if (bus.rd_data_valid) begin
              rd_line  <= line_nxt;
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (to_cnt == TO_LAST) begin
              bus.rd_err <= port_oh;
              beat_cnt   <= '0;
              to_cnt     <= '0;
              state      <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
